// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Generates the synchronous system reset from the PLL lock flag. The block
// synchronizes locked_in, waits for lock to be stable for LOCK_STABLE_CYCLES,
// holds reset for RESET_HOLD_CYCLES more, then releases sys_resetn. Losing
// lock re-asserts reset. Lock losses seen while running are counted. A
// sticky timeout flag is raised if lock is not seen for LOCK_TIMEOUT_CYCLES.
//
// Runs on the free-running PLL reference clock.
//
// Ports
//   CLK              in   PLL reference clock (only clock)
//   resetn           in   asynchronous active-low reset
//   locked_in        in   PLL lock flag, asynchronous to CLK
//   clear_count      in   synchronous clear of lock_loss_count
//   sys_resetn       out  registered active-low system reset
//   ready            out  registered, high only in RUN
//   timeout          out  sticky lock-timeout flag
//   lock_loss_count  out  saturating count of lock losses seen in RUN
//   state            out  current FSM state (encoding below)
//
// state      | meaning
// -----------+----------------------------------------------------------
// WAIT_LOCK  | waiting for synchronized lock; timeout timer runs here
// STABLE     | lock seen, checking it stays up for LOCK_STABLE_CYCLES
// HOLD       | lock confirmed, keeping reset low for RESET_HOLD_CYCLES
// RUN        | system reset released; any lock drop is a counted loss
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       locked_in,
  input  logic       clear_count,
  output logic       sys_resetn,
  output logic       ready,
  output logic       timeout,
  output logic [7:0] lock_loss_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Terminal-count values for the shared counter. TIMEOUT_LAST wraps when
  // the timeout is disabled, so it is only used behind TIMEOUT_EN.
  localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST    = 32'(RESET_HOLD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_MAX  = 32'(LOCK_TIMEOUT_CYCLES);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic        TIMEOUT_EN   = (LOCK_TIMEOUT_CYCLES != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic        sys_resetn_q, ready_q;
  logic        lock_lost;

  // Lock synchronizer; only the last stage is used by the FSM.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      loss_cnt_q   <= '0;
      sys_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      loss_cnt_q   <= loss_cnt_d;
      // Decoded from the next state so the outputs line up with state == RUN.
      sys_resetn_q <= (state_d == ST_RUN);
      ready_q      <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    lock_lost = 1'b0;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          // Saturating: the counter never passes the timeout value, so an
          // equality test is enough (and stays at 0 when disabled).
          if (cnt_q != TIMEOUT_MAX) begin
            cnt_d = cnt_q + 32'd1;
          end
          if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
            timeout_d = 1'b1;
          end
        end
      end

      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          state_d   = ST_WAIT_LOCK;
          cnt_d     = '0;
          lock_lost = 1'b1;
        end
      end

      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // A loss in the same cycle as a clear leaves a count of one, so no loss
  // is dropped by a software clear racing the event.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (clear_count) begin
      loss_cnt_d = lock_lost ? 8'd1 : 8'd0;
    end else if (lock_lost && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  assign sys_resetn      = sys_resetn_q;
  assign ready           = ready_q;
  assign timeout         = timeout_q;
  assign lock_loss_count = loss_cnt_q;
  assign state           = state_q;

endmodule
